rgb_fader: RTL and testbench

Colour sequencer that drives the three-channel 8-bit PWM stage. It holds a 4-entry RGB palette and walks through it, fading linearly from each colour to the next and holding each one. It produces the three channel duty values plus the one-cycle load strobe `en`, aligned to the PWM's 256-clock period.

---
 rtl/rgb_fader.sv | 138 +++++++++++++
 tb/tb_rgb_fader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_fader.sv
// rgb_fader: colour sequencer for the 3-channel 8-bit PWM stage.
// Walks a 4-entry RGB palette. It fades linearly by 1 LSB per PWM period toward
// each entry, then holds that colour for hold_periods extra periods.
// Ports:
//   clk, rst           system clock, async active-high reset
//   run                1 = sequence, 0 = freeze at current colour (sampled on ticks)
//   hold_periods[7:0]  extra periods to hold each colour after its fade
//   wr_en/wr_addr/wr_data  palette write port, {R,G,B} packed in 24 bits
//   value_out0/1/2     R/G/B duty values
//   en                 one-cycle load strobe, high while the period counter is 255
//   index[1:0]         palette entry currently targeted or held

// One colour channel: step one LSB toward the target.
// eq flags that the stepped value has reached the target.
module rgb_fader_lane (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] nxt,
  output logic       eq
);
  always_comb begin
    nxt = cur;
    if (cur < tgt)      nxt = cur + 8'd1;
    else if (cur > tgt) nxt = cur - 8'd1;
  end

  assign eq = (nxt == tgt);
endmodule

module rgb_fader (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  hold_periods,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [23:0] wr_data,
  output logic [7:0]  value_out0,
  output logic [7:0]  value_out1,
  output logic [7:0]  value_out2,
  output logic        en,
  output logic [1:0]  index
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FADE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [7:0]                       pcnt;
  logic                             tick;
  logic [3:0][23:0]                 pal;
  logic [NUM_LANES-1:0][VEC_W-1:0]  chan, tgt_ch, nxt_ch;
  logic [NUM_LANES-1:0]             eq;
  logic                             all_eq;
  logic [1:0]                       state;
  logic [7:0]                       hcnt;

  // Free-running period counter. Because it leaves reset at 0 together with
  // the PWM counter, the tick (254->255) lands exactly one cycle before the PWM wrap.
  assign tick = (pcnt == 8'd254);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      en   <= 1'b0;
    end else begin
      pcnt <= pcnt + 8'd1;
      en   <= tick;
    end
  end

  // Palette. Writes are accepted on any cycle. The effect on the outputs
  // only appears at the next tick, when the target is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal[0] <= 24'hFF0000;
      pal[1] <= 24'h00FF00;
      pal[2] <= 24'h0000FF;
      pal[3] <= 24'hFFFFFF;
    end else if (wr_en) begin
      pal[wr_addr] <= wr_data;
    end
  end

  // Lane 0 = red (bits 23:16), lane 1 = green, lane 2 = blue.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign tgt_ch[g] = pal[index][23-8*g -: 8];
    rgb_fader_lane u_lane (
      .cur (chan[g]),
      .tgt (tgt_ch[g]),
      .nxt (nxt_ch[g]),
      .eq  (eq[g])
    );
  end

  assign all_eq = &eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      hcnt  <= '0;
      index <= '0;
      chan  <= '0;
    end else if (tick) begin
      case (state)
        S_IDLE: if (run) state <= S_FADE;
        S_FADE: begin
          if (!run) state <= S_IDLE;
          else begin
            chan <= nxt_ch;
            // A target equal to the current colour falls through here too:
            // the step is a no-op and we go straight to HOLD.
            if (all_eq) begin
              state <= S_HOLD;
              hcnt  <= hold_periods;
            end
          end
        end
        S_HOLD: begin
          if (!run) state <= S_IDLE;
          else if (hcnt == 8'd0) begin
            index <= index + 2'd1;
            state <= S_FADE;
          end else begin
            hcnt <= hcnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign value_out0 = chan[0];
  assign value_out1 = chan[1];
  assign value_out2 = chan[2];
endmodule

// File: tb/tb_rgb_fader.sv
module tb_rgb_fader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  hold_periods = 8'd0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [23:0] wr_data = 24'd0;
  logic [7:0]  value_out0, value_out1, value_out2;
  logic        en;
  logic [1:0]  index;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  rgb_fader dut (
    .clk(clk), .rst(rst), .run(run), .hold_periods(hold_periods),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .value_out0(value_out0), .value_out1(value_out1), .value_out2(value_out2),
    .en(en), .index(index)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks colour as plain integers per channel. A "period" is 256 clocks.
  // The decision points fall on the clock where the period position moves to 255.
  int m_pos, m_mode, m_hold, m_idx;   // mode: 0 frozen, 1 fading, 2 holding
  int m_ch[3];
  int m_pal[4][3];
  bit m_en;

  function automatic void model_reset();
    m_pos = 0; m_mode = 0; m_hold = 0; m_idx = 0; m_en = 0;
    for (int c = 0; c < 3; c++) m_ch[c] = 0;
    m_pal[0] = '{255, 0, 0};
    m_pal[1] = '{0, 255, 0};
    m_pal[2] = '{0, 0, 255};
    m_pal[3] = '{255, 255, 255};
  endfunction

  always @(posedge clk or posedge rst) begin
    bit done;
    if (rst) model_reset();
    else begin
      if (m_pos == 254) begin
        if (m_mode == 0) begin
          if (run) m_mode = 1;
        end else if (!run) begin
          m_mode = 0;
        end else if (m_mode == 1) begin
          done = 1;
          for (int c = 0; c < 3; c++) begin
            if (m_ch[c] < m_pal[m_idx][c]) m_ch[c] = m_ch[c] + 1;
            else if (m_ch[c] > m_pal[m_idx][c]) m_ch[c] = m_ch[c] - 1;
            if (m_ch[c] != m_pal[m_idx][c]) done = 0;
          end
          if (done) begin m_mode = 2; m_hold = int'(hold_periods); end
        end else begin
          if (m_hold == 0) begin m_idx = (m_idx + 1) % 4; m_mode = 1; end
          else m_hold = m_hold - 1;
        end
      end
      m_en  = (m_pos == 254);
      m_pos = (m_pos + 1) % 256;
      if (wr_en) m_pal[wr_addr] = '{int'(wr_data[23:16]), int'(wr_data[15:8]), int'(wr_data[7:0])};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("en", en, m_en);
      chk("red", value_out0, m_ch[0]);
      chk("green", value_out1, m_ch[1]);
      chk("blue", value_out2, m_ch[2]);
      chk("index", index, m_idx);
    end
  end

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (en) begin ok = 1; break; end
    end
    if (!ok) chk("en_timeout", 0, 1);
  endtask

  // Hand-derived sequence: entry 0 = 030201, hold 2, then fade to 00FF00,
  // with run dropped after tick 10 and raised again after tick 12.
  int exp_rgb[14] = '{24'h000000, 24'h010101, 24'h020201, 24'h030201, 24'h030201,
                      24'h030201, 24'h030201, 24'h020300, 24'h010400, 24'h000500,
                      24'h000500, 24'h000500, 24'h000500, 24'h000600};
  int exp_idx[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    int enq[$];
    int first_en;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_on = 1;

    // Reset state, then run=0: en pulse positions and frozen outputs.
    chk("rst_red", value_out0, 0);
    chk("rst_en", en, 0);
    for (int c = 1; c <= 1030; c++) begin
      @(negedge clk);
      if (en) enq.push_back(c);
    end
    chk("en_count", enq.size(), 4);
    if (enq.size() == 4) begin
      chk("en_pos0", enq[0], 255);
      chk("en_pos1", enq[1], 511);
      chk("en_pos2", enq[2], 767);
      chk("en_pos3", enq[3], 1023);
    end
    chk("idle_rgb", {value_out0, value_out1, value_out2}, 0);
    chk("idle_idx", index, 0);

    // Directed fade/hold/pause sequence.
    wr_en = 1; wr_addr = 2'd0; wr_data = 24'h030201;
    @(negedge clk);
    wr_en = 0; hold_periods = 8'd2; run = 1;
    for (int t = 0; t < 14; t++) begin
      wait_tick();
      chk($sformatf("seq_rgb_t%0d", t + 1), {value_out0, value_out1, value_out2}, exp_rgb[t]);
      chk($sformatf("seq_idx_t%0d", t + 1), index, exp_idx[t]);
      if (t == 9)  run = 0;
      if (t == 11) run = 1;
    end

    // Randomized phase: small-valued palette, random writes, run and hold changes.
    for (int e = 0; e < 4; e++) begin
      wr_en = 1; wr_addr = 2'(e);
      wr_data = {8'($urandom_range(0, 10)), 8'($urandom_range(0, 10)), 8'($urandom_range(0, 10))};
      @(negedge clk);
    end
    wr_en = 0;
    for (int i = 0; i < 20000; i++) begin
      wr_en = ($urandom_range(0, 299) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
      if ($urandom_range(0, 1999) == 0) run = ~run;
      if ($urandom_range(0, 999) == 0) hold_periods = 8'($urandom_range(0, 3));
      @(negedge clk);
    end
    wr_en = 0;

    // Reset in the middle of HOLD.
    run = 1; hold_periods = 8'd200;
    seen = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (m_mode == 2) begin seen = 1; break; end
    end
    chk("reach_hold", seen, 1);
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_red", value_out0, 0);
    chk("arst_green", value_out1, 0);
    chk("arst_blue", value_out2, 0);
    chk("arst_en", en, 0);
    chk("arst_idx", index, 0);
    @(negedge clk);
    rst = 0;
    hold_periods = 8'd0;
    first_en = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (en) begin first_en = c; break; end
    end
    chk("first_en_after_rst", first_en, 255);
    // Tick 1 enters FADE; red then climbs 1 per tick toward the default FF.
    for (int t = 0; t < 20; t++) wait_tick();
    chk("default_red", value_out0, 20);
    chk("default_green", value_out1, 0);
    chk("default_idx", index, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
